// File: rtl/sysid_verifier.sv
// rtl/sysid_verifier.sv - Avalon-MM read master that checks the system-ID slave against build-time values
//
// Reads the ID word (address 0) and the timestamp word (address 1) from the
// sysid slave. It compares each word against the expected value and reports
// pass, fail or waitrequest timeout. It can re-run the check on a start pulse
// or on a periodic timer.
//
// Ports
//   clock            in   system clock, rising edge
//   reset            in   synchronous active-high reset
//   start            in   one-cycle launch pulse, honoured in IDLE and DONE only
//   avm_address      out  0 = ID word, 1 = timestamp word
//   avm_read         out  read strobe, held until accepted
//   avm_waitrequest  in   slave stall
//   avm_readdata     in   read data, valid READ_LATENCY cycles after accept
//   id_value         out  last captured ID word
//   ts_value         out  last captured timestamp word
//   busy             out  check in progress
//   done             out  one-cycle completion pulse (pass, fail or timeout)
//   id_ok, ts_ok     out  sticky comparison results of the last completed check
//   timeout          out  sticky: last check aborted on waitrequest timeout

module sysid_verifier #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'h5242_482E,
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned RECHECK_CYCLES = 0,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_ID  = 3'd1,
    S_LAT_ID = 3'd2,
    S_RD_TS  = 3'd3,
    S_LAT_TS = 3'd4,
    S_CHECK  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] RC_LAST = 32'(RECHECK_CYCLES - 1);
  localparam logic [1:0]  LAT_LAST = 2'(READ_LATENCY - 1);
  localparam bit          TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam bit          RC_EN    = (RECHECK_CYCLES != 0);
  localparam bit          NO_LAT   = (READ_LATENCY == 0);

  state_t      state_q, state_d;
  logic        first_q, first_d;
  logic [31:0] stall_q, stall_d;
  logic [1:0]  lat_q, lat_d;
  logic [31:0] rchk_q, rchk_d;
  logic [31:0] id_q, id_d;
  logic [31:0] ts_q, ts_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        to_q, to_d;

  logic accept;
  logic stall_hit;
  logic rchk_hit;
  logic cap_id, cap_ts, chk, to_evt;

  assign avm_read    = (state_q == S_RD_ID) || (state_q == S_RD_TS);
  assign avm_address = (state_q == S_RD_TS);
  assign accept      = avm_read && !avm_waitrequest;

  // Fires on the TIMEOUT_CYCLES-th consecutive stalled cycle of a read.
  assign stall_hit = TO_EN && avm_read && avm_waitrequest && (stall_q == TO_LAST);
  // Fires on the RECHECK_CYCLES-th cycle spent in DONE.
  assign rchk_hit  = RC_EN && (state_q == S_DONE) && (rchk_q == RC_LAST);

  always_comb begin
    state_d = state_q;
    cap_id  = 1'b0;
    cap_ts  = 1'b0;
    chk     = 1'b0;
    to_evt  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start || first_q) state_d = S_RD_ID;
      end
      S_RD_ID: begin
        if (stall_hit) begin
          to_evt  = 1'b1;
          state_d = S_DONE;
        end else if (accept) begin
          if (NO_LAT) begin
            cap_id  = 1'b1;
            state_d = S_RD_TS;
          end else begin
            state_d = S_LAT_ID;
          end
        end
      end
      S_LAT_ID: begin
        if (lat_q == LAT_LAST) begin
          cap_id  = 1'b1;
          state_d = S_RD_TS;
        end
      end
      S_RD_TS: begin
        if (stall_hit) begin
          to_evt  = 1'b1;
          state_d = S_DONE;
        end else if (accept) begin
          if (NO_LAT) begin
            cap_ts  = 1'b1;
            state_d = S_CHECK;
          end else begin
            state_d = S_LAT_TS;
          end
        end
      end
      S_LAT_TS: begin
        if (lat_q == LAT_LAST) begin
          cap_ts  = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        chk     = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        // A simultaneous start and timer expiry collapse into one re-run.
        if (start || rchk_hit) state_d = S_RD_ID;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    // Auto-start only applies to the single cycle following reset.
    first_d = 1'b0;

    // The stall and latency counters restart on every state change, so each
    // read gets a fresh stall budget even when RD_ID hands straight to RD_TS.
    if (state_d != state_q) begin
      stall_d = '0;
    end else if (avm_read && avm_waitrequest) begin
      stall_d = stall_q + 32'd1;
    end else begin
      stall_d = stall_q;
    end

    if (state_d != state_q) begin
      lat_d = '0;
    end else if ((state_q == S_LAT_ID) || (state_q == S_LAT_TS)) begin
      lat_d = lat_q + 2'd1;
    end else begin
      lat_d = lat_q;
    end

    if ((state_q == S_DONE) && (state_d == S_DONE)) begin
      rchk_d = rchk_q + 32'd1;
    end else begin
      rchk_d = '0;
    end

    id_d = cap_id ? avm_readdata : id_q;
    ts_d = cap_ts ? avm_readdata : ts_q;

    id_ok_d = id_ok_q;
    ts_ok_d = ts_ok_q;
    to_d    = to_q;
    if (chk) begin
      id_ok_d = (id_q == EXPECTED_ID);
      ts_ok_d = (ts_q == EXPECTED_TS);
      to_d    = 1'b0;
    end else if (to_evt) begin
      id_ok_d = 1'b0;
      ts_ok_d = 1'b0;
      to_d    = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      first_q <= AUTO_START;
      stall_q <= '0;
      lat_q   <= '0;
      rchk_q  <= '0;
      id_q    <= '0;
      ts_q    <= '0;
      id_ok_q <= 1'b0;
      ts_ok_q <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      stall_q <= stall_d;
      lat_q   <= lat_d;
      rchk_q  <= rchk_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
      id_ok_q <= id_ok_d;
      ts_ok_q <= ts_ok_d;
      to_q    <= to_d;
    end
  end

  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done     = chk || to_evt;
  assign id_value = id_q;
  assign ts_value = ts_q;
  assign id_ok    = id_ok_q;
  assign ts_ok    = ts_ok_q;
  assign timeout  = to_q;

endmodule

// File: tb/tb_sysid_verifier.sv
// tb/tb_sysid_verifier.sv - scoreboard bench for sysid_verifier with a latency/stall slave model

module tb_sysid_verifier;

  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'h5242_482E;
  localparam int          TO     = 8;
  localparam int          HANG   = 1000;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [1:0]       rst, st, rd, addr, wr, dn, bsy, idok, tsok, tout;
  logic [1:0][31:0] rdata, idv, tsv;

  // Slave configuration: stall cycles per address and returned words.
  int          wlen [2][2];
  logic [31:0] mem  [2][2];

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          dcyc;
    bit          idok;
    bit          tsok;
    bit          to;
    logic [31:0] idv;
    logic [31:0] tsv;
  } exp_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  sysid_verifier #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .READ_LATENCY(0),
    .TIMEOUT_CYCLES(TO), .RECHECK_CYCLES(0), .AUTO_START(1'b1)
  ) u_dut0 (
    .clock(clock), .reset(rst[0]), .start(st[0]),
    .avm_address(addr[0]), .avm_read(rd[0]), .avm_waitrequest(wr[0]),
    .avm_readdata(rdata[0]), .id_value(idv[0]), .ts_value(tsv[0]),
    .busy(bsy[0]), .done(dn[0]), .id_ok(idok[0]), .ts_ok(tsok[0]), .timeout(tout[0])
  );

  sysid_verifier #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .READ_LATENCY(2),
    .TIMEOUT_CYCLES(TO), .RECHECK_CYCLES(10), .AUTO_START(1'b1)
  ) u_dut1 (
    .clock(clock), .reset(rst[1]), .start(st[1]),
    .avm_address(addr[1]), .avm_read(rd[1]), .avm_waitrequest(wr[1]),
    .avm_readdata(rdata[1]), .id_value(idv[1]), .ts_value(tsv[1]),
    .busy(bsy[1]), .done(dn[1]), .id_ok(idok[1]), .ts_ok(tsok[1]), .timeout(tout[1])
  );

  for (genvar g = 0; g < 2; g++) begin : g_env
    localparam int RL = (g == 0) ? 0 : 2;
    localparam int RC = (g == 0) ? 0 : 10;

    int          cyc  = 0;
    int          scnt = 0;
    logic        pv [4];
    logic [31:0] pd [4];
    logic [31:0] garb;

    // Slave: stalls wlen cycles per read, returns data RL cycles after accept,
    // and presents junk at every other time so a mistimed capture is visible.
    assign garb     = {16'hBAD0, cyc[15:0]};
    assign wr[g]    = rd[g] && (scnt < wlen[g][addr[g]]);
    assign rdata[g] = (RL == 0) ? ((rd[g] && !wr[g]) ? mem[g][addr[g]] : garb)
                                : (pv[RL] ? pd[RL] : garb);

    always @(posedge clock) begin
      cyc   <= rst[g] ? 0 : cyc + 1;
      scnt  <= (rd[g] && wr[g]) ? scnt + 1 : 0;
      pv[1] <= rd[g] && !wr[g];
      pd[1] <= mem[g][addr[g]];
      pv[2] <= pv[1];
      pd[2] <= pd[1];
      pv[3] <= pv[2];
      pd[3] <= pd[2];
    end

    // Reference model: a check launched at cycle T finishes at a cycle given by
    // the stall and latency arithmetic; results follow from the slave words.
    exp_t        q [$];
    exp_t        e, pend;
    bit          pend_v = 1'b0;
    int          ph = 0;          // 0 idle, 1 running, 2 finished
    bit          auto_p = 1'b1;
    bit          trig;
    int          done_at = 0;
    int          tgt = 0;
    logic [31:0] m_id = '0;
    logic [31:0] m_ts = '0;

    always @(negedge clock) begin
      if (rst[g]) begin
        q.delete();
        pend_v = 1'b0;
        ph     = 0;
        auto_p = 1'b1;
        m_id   = '0;
        m_ts   = '0;
      end else begin
        if (pend_v) begin
          check($sformatf("u%0d_id_ok", g),   idok[g], pend.idok);
          check($sformatf("u%0d_ts_ok", g),   tsok[g], pend.tsok);
          check($sformatf("u%0d_timeout", g), tout[g], pend.to);
          check($sformatf("u%0d_id_value", g), idv[g], pend.idv);
          check($sformatf("u%0d_ts_value", g), tsv[g], pend.tsv);
          pend_v = 1'b0;
        end
        if (dn[g]) begin
          if (q.size() == 0) begin
            check($sformatf("u%0d_spurious_done", g), 1, 0);
          end else begin
            pend   = q.pop_front();
            pend_v = 1'b1;
            check($sformatf("u%0d_done_cycle", g), cyc, pend.dcyc);
          end
        end
        check($sformatf("u%0d_busy", g), bsy[g], (ph == 1));
        check($sformatf("u%0d_read_when_idle", g), rd[g] && !bsy[g], 0);

        trig = 1'b0;
        case (ph)
          0: trig = auto_p || st[g];
          1: if (cyc == tgt) begin
               check($sformatf("u%0d_done_missing", g), dn[g], 1);
               ph      = 2;
               done_at = cyc;
             end
          default: trig = st[g] || ((RC != 0) && (cyc == done_at + RC));
        endcase
        auto_p = 1'b0;

        if (trig) begin
          e.idok = 1'b0;
          e.tsok = 1'b0;
          e.to   = 1'b0;
          if (wlen[g][0] >= TO) begin
            tgt  = cyc + TO;
            e.to = 1'b1;
          end else if (wlen[g][1] >= TO) begin
            tgt  = cyc + 1 + wlen[g][0] + RL + TO;
            e.to = 1'b1;
            m_id = mem[g][0];
          end else begin
            tgt    = cyc + 3 + wlen[g][0] + wlen[g][1] + 2 * RL;
            m_id   = mem[g][0];
            m_ts   = mem[g][1];
            e.idok = (m_id == EXP_ID);
            e.tsok = (m_ts == EXP_TS);
          end
          e.dcyc = tgt;
          e.idv  = m_id;
          e.tsv  = m_ts;
          q.push_back(e);
          ph = 1;
        end
      end
    end
  end

  task automatic pulse(input int k);
    st[k] = 1'b1;
    @(posedge clock); #1;
    st[k] = 1'b0;
  endtask

  task automatic go(input int k, input int w0, input int w1,
                    input logic [31:0] m0, input logic [31:0] m1);
    int n = 0;
    while (bsy[k] && n < 300) begin
      @(posedge clock); #1;
      n++;
    end
    check($sformatf("u%0d_idle_wait", k), (n < 300), 1);
    wlen[k][0] = w0;
    wlen[k][1] = w1;
    mem[k][0]  = m0;
    mem[k][1]  = m1;
    pulse(k);
  endtask

  task automatic rand_check(input int k);
    int          w0, w1;
    logic [31:0] m0, m1;
    w0 = $urandom_range(0, 4);
    w1 = $urandom_range(0, 4);
    if ($urandom_range(0, 7) == 0) w0 = HANG;
    if ($urandom_range(0, 7) == 0) w1 = HANG;
    m0 = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
    m1 = ($urandom_range(0, 1) == 1) ? EXP_TS : (EXP_TS ^ (32'd1 << $urandom_range(0, 31)));
    go(k, w0, w1, m0, m1);
    // Start pulses while busy must be ignored.
    repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
    if (bsy[k]) pulse(k);
  endtask

  initial begin
    int n;
    rst = 2'b11;
    st  = 2'b00;
    for (int k = 0; k < 2; k++) begin
      mem[k][0] = EXP_ID;
      mem[k][1] = EXP_TS;
      wlen[k][0] = 0;
      wlen[k][1] = 0;
    end
    wlen[1][0] = 3;
    wlen[1][1] = 3;
    repeat (3) @(posedge clock);
    #1 rst = 2'b00;

    repeat (20) begin @(posedge clock); #1; end

    go(0, 0, 0, EXP_ID, 32'h5242_482F);
    go(0, 0, HANG, EXP_ID, EXP_TS);
    go(0, HANG, 0, 32'h1234_5678, EXP_TS);
    go(0, 2, 1, EXP_ID, EXP_TS);
    for (int i = 0; i < 30; i++) rand_check(0);

    for (int i = 0; i < 8; i++) rand_check(1);
    go(1, 1, 2, EXP_ID, EXP_TS);
    repeat (40) begin @(posedge clock); #1; end

    // Reset while RD_TS is stalled.
    go(0, 0, HANG, 32'hCAFE_0001, EXP_TS);
    n = 0;
    while (!(rd[0] && addr[0]) && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    check("u0_reach_rd_ts", (n < 20), 1);
    rst[0] = 1'b1;
    wlen[0][1] = 0;
    @(posedge clock);
    @(negedge clock);
    check("rst_avm_read", rd[0], 0);
    check("rst_busy", bsy[0], 0);
    check("rst_done", dn[0], 0);
    check("rst_id_ok", idok[0], 0);
    check("rst_ts_ok", tsok[0], 0);
    check("rst_timeout", tout[0], 0);
    check("rst_id_value", idv[0], 0);
    @(posedge clock); #1;
    rst[0] = 1'b0;

    repeat (30) begin @(posedge clock); #1; end
    for (int i = 0; i < 10; i++) rand_check(0);
    repeat (40) begin @(posedge clock); #1; end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
